// File: rtl/seq_shift_add_multiplier.sv
// Iterative unsigned shift-and-add multiplier built around a single parallel-prefix adder.
// prefix_tree_adder (Kogge-Stone carry tree) lives in this file alongside its only user.

module prefix_tree_adder #(
    parameter int unsigned width = 8
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             cin,
    output logic [width-1:0] sum,
    output logic             cout
);

    logic [width-1:0] g;
    logic [width-1:0] p;
    logic [width-1:0] g_nxt;
    logic [width-1:0] p_nxt;
    logic [width:0]   carry;

    // After the tree, g[i]/p[i] are group generate/propagate over bits [i:0].
    always_comb begin
        g = a & b;
        p = a ^ b;
        for (int d = 1; d < int'(width); d = d * 2) begin
            g_nxt = g;
            p_nxt = p;
            for (int i = 0; i < int'(width); i++) begin
                if (i >= d) begin
                    g_nxt[i] = g[i] | (p[i] & g[i-d]);
                    p_nxt[i] = p[i] & p[i-d];
                end
            end
            g = g_nxt;
            p = p_nxt;
        end
        carry[0] = cin;
        for (int i = 0; i < int'(width); i++) begin
            carry[i+1] = g[i] | (p[i] & cin);
        end
        sum  = a ^ b ^ carry[width-1:0];
        cout = carry[width];
    end

endmodule

module seq_shift_add_multiplier #(
    parameter int unsigned width = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [width-1:0]   a,
    input  logic [width-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*width-1:0] product
);

    localparam int unsigned CntW = $clog2(width + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e               state_q, state_d;
    logic [width-1:0]     mcand_q, mcand_d;
    logic [width-1:0]     acc_hi_q, acc_hi_d;
    logic [width-1:0]     acc_lo_q, acc_lo_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [2*width-1:0]   product_q, product_d;
    logic                 out_valid_q;

    logic [width-1:0]     add_sum;
    logic                 add_cout;
    logic [2*width-1:0]   step_val;
    logic                 last_step;

    prefix_tree_adder #(
        .width (width)
    ) u_adder (
        .a    (acc_hi_q),
        .b    (mcand_q),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // One add-and-shift step: the carry-out becomes the new top bit of the accumulator.
    always_comb begin
        if (acc_lo_q[0]) begin
            step_val = {add_cout, add_sum, acc_lo_q[width-1:1]};
        end else begin
            step_val = {1'b0, acc_hi_q, acc_lo_q[width-1:1]};
        end
        last_step = (cnt_q == CntW'(width - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mcand_q     <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            cnt_q       <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            acc_hi_q    <= acc_hi_d;
            acc_lo_q    <= acc_lo_d;
            cnt_q       <= cnt_d;
            product_q   <= product_d;
            out_valid_q <= (state_d == StDone);
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    mcand_d  = a;
                    acc_lo_d = b;
                    acc_hi_d = '0;
                    cnt_d    = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                {acc_hi_d, acc_lo_d} = step_val;
                cnt_d = cnt_q + CntW'(1);
                if (last_step) begin
                    product_d = step_val;
                    state_d   = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = out_valid_q;
        product   = product_q;
    end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench: width 8 directed cases, width 4 exhaustive, width 16 random with stalls.
// Expected products come from plain multiplication in the bench.

module tb_seq_shift_add_multiplier;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        in_valid8 = 0, in_ready8, out_valid8, out_ready8 = 1;
    logic [7:0]  a8 = 0, b8 = 0;
    logic [15:0] product8;

    logic        in_valid4 = 0, in_ready4, out_valid4, out_ready4 = 1;
    logic [3:0]  a4 = 0, b4 = 0;
    logic [7:0]  product4;

    logic        in_valid16 = 0, in_ready16, out_valid16, out_ready16 = 1;
    logic [15:0] a16 = 0, b16 = 0;
    logic [31:0] product16;

    seq_shift_add_multiplier #(.width(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .product   (product8)
    );

    seq_shift_add_multiplier #(.width(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .product   (product4)
    );

    seq_shift_add_multiplier #(.width(16)) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .a         (a16),
        .b         (b16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .product   (product16)
    );

    // Drives one width-8 operand pair and returns cycles from acceptance to out_valid (-1 = none).
    task automatic issue8(input logic [7:0] ta, input logic [7:0] tb, output int lat);
        a8 = ta;
        b8 = tb;
        in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (out_valid8) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (in_ready8 !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready got=%b want=1", in_ready8);
        end
        total++;
        if (out_valid8 !== 1'b0) begin
            bad++;
            $display("FAIL reset_out_valid got=%b want=0", out_valid8);
        end
        total++;
        if (product8 !== 16'h0000) begin
            bad++;
            $display("FAIL reset_product got=%h want=0000", product8);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle in_ready=%b out_valid=%b want 1/0", in_ready8, out_valid8);
        end
    endtask

    task automatic test_max_operands;
        int lat;
        logic [15:0] exp;
        exp = 16'(8'hFF) * 16'(8'hFF);
        out_ready8 = 1'b1;
        issue8(8'hFF, 8'hFF, lat);
        total++;
        if (lat !== 8) begin
            bad++;
            $display("FAIL max_latency got=%0d want=8", lat);
        end
        total++;
        if (product8 !== exp) begin
            bad++;
            $display("FAIL max_product got=%h want=%h", product8, exp);
        end
        @(posedge clk); #1;
        total++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
            bad++;
            $display("FAIL max_handshake out_valid=%b in_ready=%b want 0/1", out_valid8, in_ready8);
        end
    endtask

    task automatic test_zero_operands;
        logic [7:0] za [2];
        logic [7:0] zb [2];
        int lat;
        za[0] = 8'h00; zb[0] = 8'hA5;
        za[1] = 8'h37; zb[1] = 8'h00;
        for (int i = 0; i < 2; i++) begin
            issue8(za[i], zb[i], lat);
            total++;
            if (lat !== 8) begin
                bad++;
                $display("FAIL zero_latency[%0d] got=%0d want=8", i, lat);
            end
            total++;
            if (product8 !== 16'(za[i]) * 16'(zb[i])) begin
                bad++;
                $display("FAIL zero_product[%0d] got=%h want=0000", i, product8);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure;
        int lat;
        logic [15:0] exp1;
        logic [15:0] exp2;
        int stable_err;
        exp1 = 16'(8'h12) * 16'(8'h34);
        exp2 = 16'(8'h56) * 16'(8'h78);
        out_ready8 = 1'b0;
        issue8(8'h12, 8'h34, lat);
        total++;
        if (lat !== 8) begin
            bad++;
            $display("FAIL bp_latency got=%0d want=8", lat);
        end
        a8 = 8'h56;
        b8 = 8'h78;
        in_valid8 = 1'b1;
        stable_err = 0;
        for (int c = 0; c < 5; c++) begin
            if (out_valid8 !== 1'b1 || in_ready8 !== 1'b0 || product8 !== exp1) stable_err++;
            @(posedge clk); #1;
        end
        total++;
        if (stable_err != 0 || product8 !== exp1) begin
            bad++;
            $display("FAIL bp_hold bad_cycles=%0d product=%h want=%h", stable_err, product8, exp1);
        end
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
            bad++;
            $display("FAIL bp_release out_valid=%b in_ready=%b want 0/1", out_valid8, in_ready8);
        end
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        total++;
        if (in_ready8 !== 1'b0) begin
            bad++;
            $display("FAIL bp_next_accept in_ready=%b want=0", in_ready8);
        end
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (out_valid8) begin
                lat = c;
                break;
            end
        end
        total++;
        if (lat !== 8 || product8 !== exp2) begin
            bad++;
            $display("FAIL bp_second latency=%0d product=%h want 8/%h", lat, product8, exp2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run;
        int seen;
        int lat;
        a8 = 8'hC3;
        b8 = 8'h5A;
        in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || product8 !== 16'h0000) begin
            bad++;
            $display("FAIL midrun_reset in_ready=%b out_valid=%b product=%h want 1/0/0000",
                     in_ready8, out_valid8, product8);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (out_valid8 !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL midrun_ghost_result out_valid_cycles=%0d want=0", seen);
        end
        issue8(8'hC3, 8'h5A, lat);
        total++;
        if (lat !== 8 || product8 !== 16'(8'hC3) * 16'(8'h5A)) begin
            bad++;
            $display("FAIL midrun_recover latency=%0d product=%h want 8/%h",
                     lat, product8, 16'(8'hC3) * 16'(8'h5A));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_w4_exhaustive;
        logic [7:0] q[$];
        int idx, got, cyc, last_acc;
        logic fi, fo;
        logic [3:0] pa, pb;
        logic [7:0] pp, exp;
        idx = 0; got = 0; cyc = 0; last_acc = -1;
        a4 = 4'd0; b4 = 4'd0; in_valid4 = 1'b1; out_ready4 = 1'b1;
        while (got < 256 && cyc < 256 * 6 + 40) begin
            fi = in_valid4 && in_ready4;
            fo = out_valid4 && out_ready4;
            pa = a4; pb = b4; pp = product4;
            @(posedge clk); #1;
            cyc++;
            if (fo) begin
                got++;
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL w4_unexpected_result product=%h want none", pp);
                end else begin
                    exp = q.pop_front();
                    if (pp !== exp) begin
                        bad++;
                        $display("FAIL w4_product got=%h want=%h", pp, exp);
                    end
                end
            end
            if (fi) begin
                q.push_back(8'(pa) * 8'(pb));
                if (last_acc >= 0) begin
                    total++;
                    if (cyc - last_acc != 6) begin
                        bad++;
                        $display("FAIL w4_interval got=%0d want=6", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                idx++;
                if (idx < 256) begin
                    {a4, b4} = idx[7:0];
                end else begin
                    in_valid4 = 1'b0;
                end
            end
        end
        in_valid4 = 1'b0;
        total++;
        if (got != 256) begin
            bad++;
            $display("FAIL w4_count got=%0d want=256", got);
        end
    endtask

    task automatic test_w16_random;
        localparam int N = 2500;
        logic [31:0] q[$];
        int sent, got, cyc, overlap;
        logic fi, fo;
        logic [15:0] pa, pb;
        logic [31:0] pp, exp;
        sent = 0; got = 0; cyc = 0; overlap = 0;
        in_valid16 = 1'b0;
        while (got < N && cyc < N * 28) begin
            if (out_valid16 && in_ready16) overlap++;
            fi = in_valid16 && in_ready16;
            fo = out_valid16 && out_ready16;
            pa = a16; pb = b16; pp = product16;
            @(posedge clk); #1;
            cyc++;
            if (fo) begin
                got++;
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL w16_unexpected_result product=%h want none", pp);
                end else begin
                    exp = q.pop_front();
                    if (pp !== exp) begin
                        bad++;
                        $display("FAIL w16_product got=%h want=%h", pp, exp);
                    end
                end
            end
            if (fi) begin
                q.push_back(32'(pa) * 32'(pb));
                in_valid16 = 1'b0;
            end
            if (!in_valid16 && sent < N && $urandom_range(0, 1) == 1) begin
                a16 = 16'($urandom);
                b16 = 16'($urandom);
                if ($urandom_range(0, 7) == 0) a16 = 16'hFFFF;
                if ($urandom_range(0, 7) == 0) b16 = 16'hFFFF;
                in_valid16 = 1'b1;
                sent++;
            end
            out_ready16 = ($urandom_range(0, 3) != 0);
        end
        in_valid16 = 1'b0;
        out_ready16 = 1'b1;
        total++;
        if (got != N || q.size() != 0) begin
            bad++;
            $display("FAIL w16_count got=%0d pending=%0d want %0d/0", got, q.size(), N);
        end
        total++;
        if (overlap != 0) begin
            bad++;
            $display("FAIL w16_ready_while_valid cycles=%0d want=0", overlap);
        end
    endtask

    initial begin
        test_reset();
        test_max_operands();
        test_zero_operands();
        test_backpressure();
        test_reset_mid_run();
        test_w4_exhaustive();
        test_w16_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
